// File: rtl/i2c_target_core.sv
// I2C target byte engine: oversampled START/STOP detection, 7-bit address match,
// write-byte delivery to user logic and read-byte fetch from it (no clock stretching).
`timescale 1ns/1ps
module i2c_target_core #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack_en,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       busy,
    output logic       rd_mode,
    output logic       start_det,
    output logic       stop_det,
    output logic       nack_seen
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_MACK,
        ST_WAIT_STOP
    } state_t;

    // Synchronizers reset to the idle-bus level so reset release never looks like an edge
    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_hist_reg;
    logic                   sda_hist_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
            scl_hist_reg <= scl_sync_reg[SYNC_STAGES-1];
            sda_hist_reg <= sda_sync_reg[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_cond;
    logic stop_cond;

    assign scl_s      = scl_sync_reg[SYNC_STAGES-1];
    assign sda_s      = sda_sync_reg[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_hist_reg;
    assign scl_fall   = ~scl_s & scl_hist_reg;
    assign start_cond = scl_s & sda_hist_reg & ~sda_s;
    assign stop_cond  = scl_s & ~sda_hist_reg & sda_s;

    state_t     state_reg,     state_next;
    logic [2:0] bit_cnt_reg,   bit_cnt_next;
    logic [7:0] shift_reg,     shift_next;
    logic [7:0] tx_shift_reg,  tx_shift_next;
    logic [7:0] rx_data_reg,   rx_data_next;
    logic       ack_en_reg,    ack_en_next;
    logic       phase_reg,     phase_next;
    logic       sda_oe_reg,    sda_oe_next;
    logic       busy_reg,      busy_next;
    logic       rd_mode_reg,   rd_mode_next;
    logic       rx_valid_reg,  rx_valid_next;
    logic       tx_load_reg,   tx_load_next;
    logic       start_det_reg, start_det_next;
    logic       stop_det_reg,  stop_det_next;
    logic       nack_seen_reg, nack_seen_next;
    logic [7:0] shift_in;

    assign shift_in = {shift_reg[6:0], sda_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= 3'd0;
            shift_reg     <= 8'h00;
            tx_shift_reg  <= 8'h00;
            rx_data_reg   <= 8'h00;
            ack_en_reg    <= 1'b0;
            phase_reg     <= 1'b0;
            sda_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            rd_mode_reg   <= 1'b0;
            rx_valid_reg  <= 1'b0;
            tx_load_reg   <= 1'b0;
            start_det_reg <= 1'b0;
            stop_det_reg  <= 1'b0;
            nack_seen_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            tx_shift_reg  <= tx_shift_next;
            rx_data_reg   <= rx_data_next;
            ack_en_reg    <= ack_en_next;
            phase_reg     <= phase_next;
            sda_oe_reg    <= sda_oe_next;
            busy_reg      <= busy_next;
            rd_mode_reg   <= rd_mode_next;
            rx_valid_reg  <= rx_valid_next;
            tx_load_reg   <= tx_load_next;
            start_det_reg <= start_det_next;
            stop_det_reg  <= stop_det_next;
            nack_seen_reg <= nack_seen_next;
        end
    end

    // phase_reg marks the second half of a two-fall step (ACK driven / byte complete)
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        tx_shift_next  = tx_shift_reg;
        rx_data_next   = rx_data_reg;
        ack_en_next    = ack_en_reg;
        phase_next     = phase_reg;
        sda_oe_next    = sda_oe_reg;
        busy_next      = busy_reg;
        rd_mode_next   = rd_mode_reg;
        rx_valid_next  = 1'b0;
        tx_load_next   = 1'b0;
        start_det_next = 1'b0;
        stop_det_next  = 1'b0;
        nack_seen_next = 1'b0;

        if (start_cond) begin
            state_next     = ST_ADDR;
            bit_cnt_next   = 3'd0;
            phase_next     = 1'b0;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b0;
            start_det_next = 1'b1;
        end else if (stop_cond) begin
            state_next    = ST_IDLE;
            bit_cnt_next  = 3'd0;
            phase_next    = 1'b0;
            sda_oe_next   = 1'b0;
            busy_next     = 1'b0;
            stop_det_next = 1'b1;
        end else begin
            case (state_reg)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (shift_in[7:1] == DEV_ADDR) begin
                                rd_mode_next = shift_in[0];
                                busy_next    = 1'b1;
                                state_next   = ST_ADDR_ACK;
                            end else begin
                                state_next = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_reg) begin
                            sda_oe_next = 1'b1;
                            phase_next  = 1'b1;
                        end else begin
                            phase_next  = 1'b0;
                            sda_oe_next = 1'b0;
                            if (rd_mode_reg) begin
                                tx_shift_next = tx_data;
                                tx_load_next  = 1'b1;
                                sda_oe_next   = ~tx_data[7];
                                state_next    = ST_RD_DATA;
                            end else begin
                                state_next = ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise && !phase_reg) begin
                        shift_next   = shift_in;
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            rx_data_next  = shift_in;
                            rx_valid_next = 1'b1;
                            ack_en_next   = rx_ack_en;
                            phase_next    = 1'b1;
                        end
                    end else if (scl_fall && phase_reg) begin
                        sda_oe_next = ack_en_reg;
                        phase_next  = 1'b0;
                        state_next  = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next = 1'b0;
                        state_next  = ack_en_reg ? ST_WR_DATA : ST_WAIT_STOP;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            sda_oe_next = 1'b0;
                            state_next  = ST_RD_MACK;
                        end else begin
                            sda_oe_next   = ~tx_shift_reg[6];
                            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                        end
                    end
                end
                ST_RD_MACK: begin
                    if (scl_rise && !phase_reg) begin
                        if (sda_s) begin
                            nack_seen_next = 1'b1;
                            state_next     = ST_WAIT_STOP;
                        end else begin
                            phase_next = 1'b1;
                        end
                    end else if (scl_fall && phase_reg) begin
                        phase_next    = 1'b0;
                        tx_shift_next = tx_data;
                        tx_load_next  = 1'b1;
                        sda_oe_next   = ~tx_data[7];
                        state_next    = ST_RD_DATA;
                    end
                end
                ST_WAIT_STOP: begin
                    sda_oe_next = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe    = sda_oe_reg;
    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign tx_load   = tx_load_reg;
    assign busy      = busy_reg;
    assign rd_mode   = rd_mode_reg;
    assign start_det = start_det_reg;
    assign stop_det  = stop_det_reg;
    assign nack_seen = nack_seen_reg;

endmodule
